// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter sharing one req/ack/data channel among NUM_REQ requesters.
// Define REQ_ACK_TIMEOUT_EN to enable the ack timeout and timeout_err pulse.
module req_ack_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vec,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt_vec,
  output logic                      req,
  output logic [DATA_W-1:0]         data,
  input  logic                      ack,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ACK_TIMEOUT < 1) begin : g_param_chk
    $error("req_ack_arbiter: illegal parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [PTR_W-1:0]   pick;
  logic               found;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               expired;

  logic [NUM_REQ-1:0][DATA_W-1:0] lane;

  assign lane = req_data;

  // First pending requester at or above ptr_q, wrapping.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] ip;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    ip    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      ip  = PTR_W'(idx);
      if (!found && req_vec[ip]) begin
        found = 1'b1;
        pick  = ip;
      end
    end
  end

`ifdef REQ_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      state_q == S_IDLE: cnt_d = found ? CNT_W'(1) : '0;
      state_q == S_REQ: begin
        if (!expired) cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CNT_MAX);
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (found) state_d = S_REQ;
      S_REQ:   if (ack || expired) state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = gnt_q;
    data_d = data_q;
    req_d  = req_q;
    win_d  = win_q;
    ptr_d  = ptr_q;
    done_d = 1'b0;
    tmo_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          data_d      = lane[pick];
          req_d       = 1'b1;
        end
      end
      S_REQ: begin
        // ack beats an expiring counter in the same cycle
        if (ack) begin
          req_d  = 1'b0;
          done_d = 1'b1;
        end else if (expired) begin
          req_d = 1'b0;
          tmo_d = 1'b1;
        end
      end
      S_REL: begin
        gnt_d = '0;
        ptr_d = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        gnt_d = '0;
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      data_q <= '0;
      req_q  <= 1'b0;
      win_q  <= '0;
      ptr_q  <= '0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      data_q <= data_d;
      req_q  <= req_d;
      win_q  <= win_d;
      ptr_q  <= ptr_d;
      done_q <= done_d;
      tmo_q  <= tmo_d;
    end
  end

  assign gnt_vec     = gnt_q;
  assign data        = data_q;
  assign req         = req_q;
  assign done        = done_q;
  assign timeout_err = tmo_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Randomised and directed bench for req_ack_arbiter.
// Checks every cycle against a rule-level reference model.
module tb_req_ack_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 15;
`ifdef REQ_ACK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_vec;
  logic [N*W-1:0] req_data;
  logic           ack;
  logic [N-1:0]   gnt_vec;
  logic           req;
  logic [W-1:0]   data;
  logic           done;
  logic           timeout_err;
  logic           busy;

  req_ack_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vec    (req_vec),
    .req_data   (req_data),
    .gnt_vec    (gnt_vec),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .done       (done),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction phase plus expected outputs.
  int           m_ph;
  int           m_win;
  int           m_ptr;
  int           m_age;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_data;
  bit           m_req;
  bit           m_done;
  bit           m_tmo;

  task automatic model_reset();
    m_ph = 0; m_win = 0; m_ptr = 0; m_age = 0;
    m_gnt = '0; m_data = '0;
    m_req = 0; m_done = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    bit hit;
    int i;
    m_done = 0;
    m_tmo  = 0;
    if (m_ph == 0) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!hit && req_vec[i]) begin
          hit = 1;
          m_win = i;
        end
      end
      if (hit) begin
        m_gnt = '0;
        m_gnt[m_win] = 1'b1;
        m_data = req_data[m_win*W +: W];
        m_req = 1;
        m_age = 1;
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (ack) begin
        m_req = 0; m_done = 1; m_ph = 2;
      end else if (TMO_EN && m_age == TMO) begin
        m_req = 0; m_tmo = 1; m_ph = 2;
      end else begin
        m_age++;
      end
    end else begin
      m_gnt = '0;
      m_ptr = (m_win + 1) % N;
      m_ph = 0;
    end
  endtask

  task automatic compare(input string p);
    chk({p, ".req"},    32'(req),         32'(m_req));
    chk({p, ".gnt"},    32'(gnt_vec),     32'(m_gnt));
    chk({p, ".data"},   32'(data),        32'(m_data));
    chk({p, ".done"},   32'(done),        32'(m_done));
    chk({p, ".tmo"},    32'(timeout_err), 32'(m_tmo));
    chk({p, ".busy"},   32'(busy),        32'(m_ph != 0));
    chk({p, ".onehot"}, 32'($onehot0(gnt_vec)), 32'd1);
    chk({p, ".excl"},   32'(done & timeout_err), 32'd0);
  endtask

  task automatic cyc(input string p, input logic [N-1:0] rv, input bit a);
    req_vec = rv;
    ack     = a;
    @(posedge clk);
    model_step();
    #1;
    compare(p);
  endtask

  task automatic do_reset(input logic [N-1:0] rv, input bit a, input int n);
    req_vec = rv;
    ack     = a;
    rst_n   = 1'b0;
    #1;
    model_reset();
    compare("rst_async");
    repeat (n) begin
      @(posedge clk);
      #1;
      compare("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int got_order[$];
  int lows[$];
  int lowc;
  int hi;
  int guard;
  logic [N-1:0] prev_gnt;

  initial begin
    req_vec  = '0;
    req_data = '0;
    ack      = 1'b0;
    #2;

    // Reset with requests and ack pending
    do_reset(4'hF, 1'b1, 3);
    repeat (3) cyc("post_rst", 4'h0, 1'b0);
    chk("post_rst.busy", 32'(busy), 32'd0);

    // Single request
    req_data = $urandom();
    req_data[2*W +: W] = 8'hA5;
    cyc("single", 4'b0100, 1'b0);
    chk("single.gnt", 32'(gnt_vec), 32'h4);
    chk("single.data", 32'(data), 32'hA5);
    chk("single.req", 32'(req), 32'd1);
    req_data = $urandom();
    cyc("single", 4'b0000, 1'b0);
    chk("single.hold", 32'(data), 32'hA5);
    cyc("single", 4'b0000, 1'b1);
    chk("single.done", 32'(done), 32'd1);
    chk("single.reqlow", 32'(req), 32'd0);
    repeat (2) cyc("single", 4'b0000, 1'b0);

    // Round-robin with all requesting
    do_reset(4'h0, 1'b0, 1);
    got_order.delete();
    lows.delete();
    lowc = 0;
    prev_gnt = '0;
    guard = 0;
    while (got_order.size() < 5 && guard < 60) begin
      cyc("rr", 4'hF, req);
      guard++;
      if (gnt_vec != '0 && prev_gnt == '0) begin
        for (int k = 0; k < N; k++)
          if (gnt_vec[k]) got_order.push_back(k);
        if (got_order.size() > 1) lows.push_back(lowc);
        lowc = 0;
      end else if (!req) begin
        lowc++;
      end
      prev_gnt = gnt_vec;
    end
    chk("rr.count", 32'(got_order.size()), 32'd5);
    foreach (got_order[k])
      if (k < 5) chk("rr.order", 32'(got_order[k]), 32'(exp_order[k]));
    foreach (lows[k]) chk("rr.gap", 32'(lows[k]), 32'd2);
    repeat (3) cyc("rr", 4'h0, 1'b0);

`ifdef REQ_ACK_TIMEOUT_EN
    // Timeout: ack never arrives
    do_reset(4'h0, 1'b0, 1);
    cyc("tmo", 4'b0010, 1'b0);
    hi = req ? 1 : 0;
    guard = 0;
    while (req && guard < 40) begin
      cyc("tmo", 4'b1011, 1'b0);
      guard++;
      if (req) hi++;
    end
    chk("tmo.len", 32'(hi), 32'd15);
    chk("tmo.pulse", 32'(timeout_err), 32'd1);
    chk("tmo.done", 32'(done), 32'd0);
    cyc("tmo", 4'b1011, 1'b0);
    cyc("tmo", 4'b1011, 1'b0);
    chk("tmo.next", 32'(gnt_vec), 32'h8);
    cyc("tmo", 4'b0000, 1'b1);
    repeat (2) cyc("tmo", 4'b0000, 1'b0);
`else
    // No timeout: REQ waits indefinitely
    do_reset(4'h0, 1'b0, 1);
    cyc("wait", 4'b0010, 1'b0);
    repeat (40) cyc("wait", 4'b0000, 1'b0);
    chk("wait.req", 32'(req), 32'd1);
    chk("wait.tmo", 32'(timeout_err), 32'd0);
    cyc("wait", 4'b0000, 1'b1);
    chk("wait.done", 32'(done), 32'd1);
    repeat (2) cyc("wait", 4'b0000, 1'b0);
`endif

    // Ack arrives in the last allowed REQ cycle
    do_reset(4'h0, 1'b0, 1);
    cyc("tie", 4'b0001, 1'b0);
    repeat (14) cyc("tie", 4'b0000, 1'b0);
    chk("tie.req", 32'(req), 32'd1);
    cyc("tie", 4'b0000, 1'b1);
    chk("tie.done", 32'(done), 32'd1);
    chk("tie.tmo", 32'(timeout_err), 32'd0);
    repeat (2) cyc("tie", 4'b0000, 1'b0);

    // Reset in REQ cycle 3, then stray ack while idle
    cyc("midrst", 4'b0100, 1'b0);
    cyc("midrst", 4'b0000, 1'b0);
    cyc("midrst", 4'b0000, 1'b0);
    do_reset(4'h0, 1'b0, 1);
    chk("midrst.req", 32'(req), 32'd0);
    repeat (3) cyc("stray", 4'b0000, 1'b1);
    chk("stray.busy", 32'(busy), 32'd0);
    chk("stray.done", 32'(done), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      req_data = $urandom();
      if ($urandom_range(0, 499) == 0)
        do_reset(N'($urandom()), 1'($urandom()), 1);
      else
        cyc("rand", N'($urandom()), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
